// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the MEM stage
// and a 256-bit block memory; hits are combinational, misses stall until the line is filled.
module dcache_ctrl #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_req_i,
    input  logic                 p1_write_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WSEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [NUM_LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]   data_q [NUM_LINES];
    logic [ADDR_W-1:0]      miss_addr_q, miss_addr_d;

    logic                   mem_enable_q, mem_enable_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]   mem_data_q, mem_data_d;

    // Array write port, shared by the write-hit and the fill paths
    logic                   line_we_c;
    logic                   tag_we_c;
    logic [IDX_W-1:0]       line_widx_c;
    logic [LINE_BITS-1:0]   line_wdata_c;

    logic [IDX_W-1:0]       req_idx, miss_idx;
    logic [TAG_W-1:0]       req_tag, miss_tag;
    logic [WSEL_W-1:0]      req_wsel;
    logic [7:0]             word_lsb;
    logic [LINE_BITS-1:0]   req_line;
    logic                   hit_c, idle_c, miss_c, write_hit_c, victim_dirty_c;
    logic                   unused_c;

    assign req_idx  = p1_addr_i[OFF_W +: IDX_W];
    assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_wsel = p1_addr_i[2 +: WSEL_W];
    assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];
    assign word_lsb = {req_wsel, 5'd0};
    assign req_line = data_q[req_idx];
    assign unused_c = ^{p1_addr_i[1:0], miss_addr_q[OFF_W-1:0]};

    assign hit_c          = p1_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign idle_c         = (state_q == ST_IDLE);
    assign miss_c         = p1_req_i & ~hit_c & idle_c;
    assign write_hit_c    = p1_req_i & p1_write_i & hit_c & idle_c;
    assign victim_dirty_c = valid_q[req_idx] & dirty_q[req_idx];

    // Stall is gated by reset so it drops the moment reset asserts
    assign p1_stall_o = rst_i & p1_req_i & (~hit_c | ~idle_c);
    assign p1_data_o  = hit_c ? req_line[word_lsb +: WORD_W] : '0;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acks are only meaningful while a transfer is outstanding
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_c) begin
                    state_d = victim_dirty_c ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and line-update logic; memory request fields hold unless a transition changes them
    always_comb begin
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        miss_addr_d  = miss_addr_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        line_we_c    = 1'b0;
        tag_we_c     = 1'b0;
        line_widx_c  = req_idx;
        line_wdata_c = req_line;
        case (state_q)
            ST_IDLE: begin
                if (miss_c) begin
                    miss_addr_d  = p1_addr_i;
                    mem_enable_d = 1'b1;
                    if (victim_dirty_c) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[req_idx], req_idx, OFF_W'(0)};
                        mem_data_d  = req_line;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, OFF_W'(0)};
                        mem_data_d  = '0;
                    end
                end else if (write_hit_c) begin
                    line_we_c                         = 1'b1;
                    line_wdata_c[word_lsb +: WORD_W]  = p1_data_i;
                    dirty_d[req_idx]                  = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    dirty_d[miss_idx] = 1'b0;
                    mem_write_d       = 1'b0;
                    mem_addr_d        = {miss_tag, miss_idx, OFF_W'(0)};
                    mem_data_d        = '0;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    line_we_c         = 1'b1;
                    tag_we_c          = 1'b1;
                    line_widx_c       = miss_idx;
                    line_wdata_c      = mem_data_i;
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    mem_enable_d      = 1'b0;
                    mem_write_d       = 1'b0;
                    mem_addr_d        = '0;
                    mem_data_d        = '0;
                end
            end
            default: begin
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // Control registers; reset abandons any outstanding transfer
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_addr_q  <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            miss_addr_q  <= miss_addr_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Tag and data arrays are not reset; valid qualifies them
    always_ff @(posedge clk_i) begin
        if (line_we_c) begin
            data_q[line_widx_c] <= line_wdata_c;
        end
        if (tag_we_c) begin
            tag_q[line_widx_c] <= miss_tag;
        end
    end

endmodule
